// File: rtl/clock_pkg.sv
// Shared types and constants for the clock timekeeping / time-set controller.
package clock_pkg;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      SET_HR  = 2'd1,
      SET_MIN = 2'd2
   } state_t;

   localparam logic [3:0] HOUR_MIN = 4'd1;
   localparam logic [3:0] HOUR_MAX = 4'd12;
   localparam logic [5:0] MIN_MAX  = 6'd59;
   localparam logic [5:0] SEC_MAX  = 6'd59;

   // 12-hour wrap: 12 is followed by 1
   function automatic logic [3:0] hour_next(input logic [3:0] h);
      return (h == HOUR_MAX) ? HOUR_MIN : h + 4'd1;
   endfunction

endpackage

// File: rtl/clock_ctrl_btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter and a
// single-cycle pulse on each accepted press (nothing on release).
module btn_debounce #(
   parameter int DB_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic press
);

   localparam int             CW      = $clog2(DB_CYCLES + 1);
   localparam logic [CW-1:0]  CNT_MAX = CW'(DB_CYCLES - 1);

   logic          sync1, sync2, level;
   logic [CW-1:0] cnt;
   logic          flip;

   assign flip = (sync2 != level) && (cnt == CNT_MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         level <= 1'b0;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         // any agreeing sample restarts the stability window
         if (sync2 == level || flip)
            cnt <= '0;
         else
            cnt <= cnt + CW'(1);
         if (flip)
            level <= ~level;
         press <= flip & ~level;
      end
   end

endmodule

// File: rtl/clock_ctrl.sv
// Clock timekeeping: 1 Hz prescaler, h:m:s counters (12-hour with AM/PM),
// RUN/SET_HR/SET_MIN mode FSM and blink control for the field being edited.
module clock_ctrl
   import clock_pkg::*;
#(
   parameter int TICK_DIV  = 100_000_000,
   parameter int DB_CYCLES = 1_000_000,
   parameter int BLINK_DIV = 25_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_mode,
   input  logic       btn_inc,
   output logic [3:0] hour,
   output logic [5:0] min,
   output logic [5:0] sec,
   output logic       pm,
   output logic       blank_hour,
   output logic       blank_min,
   output logic       setting
);

   localparam int            PW        = $clog2(TICK_DIV);
   localparam int            BW        = $clog2(BLINK_DIV);
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
   localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

   state_t        state, state_nxt;
   logic          mode_press, inc_press;
   logic [PW-1:0] presc;
   logic [BW-1:0] blink_cnt;
   logic          blink_phase;
   logic          tick, inc_ok, enter_set;

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_mode (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_mode),
      .press (mode_press)
   );

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_inc (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_inc),
      .press (inc_press)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= RUN;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (mode_press) begin
         case (state)
            RUN:     state_nxt = SET_HR;
            SET_HR:  state_nxt = SET_MIN;
            default: state_nxt = RUN;
         endcase
      end
   end

   // a mode press always wins over a same-cycle tick or increment
   assign tick      = (state == RUN) && (presc == PRESC_MAX) && !mode_press;
   assign inc_ok    = inc_press && !mode_press && (state != RUN);
   assign enter_set = mode_press && (state_nxt != RUN);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         setting     <= 1'b0;
         presc       <= '0;
         hour        <= HOUR_MAX;
         min         <= '0;
         sec         <= '0;
         pm          <= 1'b0;
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else begin
         setting <= (state_nxt != RUN);

         // held at zero outside RUN so the first tick after SET_MIN is a full period
         if (state != RUN || mode_press || presc == PRESC_MAX)
            presc <= '0;
         else
            presc <= presc + PW'(1);

         if (mode_press && state == RUN) begin
            sec <= '0;
         end else if (tick) begin
            if (sec == SEC_MAX) begin
               sec <= '0;
               if (min == MIN_MAX) begin
                  min  <= '0;
                  hour <= hour_next(hour);
                  if (hour == HOUR_MAX - 4'd1)
                     pm <= ~pm;
               end else begin
                  min <= min + 6'd1;
               end
            end else begin
               sec <= sec + 6'd1;
            end
         end else if (inc_ok) begin
            if (state == SET_HR) begin
               hour <= hour_next(hour);
               if (hour == HOUR_MAX - 4'd1)
                  pm <= ~pm;
            end else begin
               min <= (min == MIN_MAX) ? 6'd0 : min + 6'd1;
            end
         end

         // restart blinking visible so an edit is seen for a full half-period
         if (enter_set || inc_ok) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
         end else if (blink_cnt == BLINK_MAX) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt + BW'(1);
         end
      end
   end

   assign blank_hour = (state == SET_HR)  && blink_phase;
   assign blank_min  = (state == SET_MIN) && blink_phase;

endmodule
